// File: rtl/simplebus_pkg.sv
// simplebus_pkg: shared state encoding, default width and counter sizing for the simple-bus follower.
package simplebus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, RD_DATA, WR_WAIT} simplebus_fstate_t;
  localparam int DEF_DATA_W = 8;
  function automatic int cnt_w(input int max_val);
    return max_val < 2 ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/simplebus_mem_array.sv
// simplebus_mem_array: synchronous-write, asynchronous-read memory preloaded with INIT.
module simplebus_mem_array import simplebus_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_AW = 16,
  parameter logic [DATA_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**MEM_AW] = '{default: INIT};
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/simplebus_follower_mem.sv
// simplebus_follower_mem: parametrised memory follower on the multiplexed-address simple bus.
// Optional write-wait timeout with err pulse when SIMPLEBUS_WR_TIMEOUT_EN is defined.
module simplebus_follower_mem import simplebus_pkg::*; #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_BEATS = 3,
  parameter int BANK_ID    = 0,
  parameter int MEM_AW     = 16,
  parameter int RD_LATENCY = 2,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              read,
  input  logic              burst,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic              dv_in,
  output logic              dv_out,
  output logic              dv_oe,
  output logic              busy,
  output logic              err
);
  localparam int BW = cnt_w(ADDR_BEATS - 1);
  localparam int LW = cnt_w(RD_LATENCY);
  localparam int RW = cnt_w(BURST_LEN - 1);
  localparam int FW = (ADDR_BEATS - 1) * DATA_W;
  localparam logic [DATA_W-1:0] BANK = DATA_W'(BANK_ID);
  simplebus_fstate_t state;
  logic [BW-1:0] beat_cnt;
  logic [LW-1:0] lat_cnt;
  logic [RW-1:0] remain;
  logic [DATA_W-1:0] slot [ADDR_BEATS-1];
  logic [FW-1:0] full;
  logic [MEM_AW-1:0] idx;
  logic [DATA_W-1:0] rd;
  logic we, rd_on;
  // Final beat is taken straight from the bus so idx is ready the cycle after it.
  always_comb begin
    full = '0;
    for (int i = 1; i < ADDR_BEATS - 1; i++) full[(ADDR_BEATS-1-i)*DATA_W +: DATA_W] = slot[i];
    full[DATA_W-1:0] = address;
  end
  assign we       = state == WR_WAIT && dv_in;
  assign rd_on    = state == RD_DATA;
  assign data_oe  = rd_on;
  assign dv_oe    = rd_on;
  assign dv_out   = rd_on;
  assign data_out = rd_on ? rd : '0;
  assign busy     = state != IDLE;
  simplebus_mem_array #(.DATA_W(DATA_W), .MEM_AW(MEM_AW), .INIT(BANK)) u_mem (
    .clk(clock), .we(we), .addr(idx), .wdata(data_in), .rdata(rd)
  );
`ifdef SIMPLEBUS_WR_TIMEOUT_EN
  localparam int SW = cnt_w(TIMEOUT);
  logic [SW-1:0] stall;
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      remain   <= '0;
      idx      <= '0;
      slot     <= '{default: '0};
`ifdef SIMPLEBUS_WR_TIMEOUT_EN
      stall    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef SIMPLEBUS_WR_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          slot[0]  <= address;
          beat_cnt <= BW'(1);
          state    <= ADDR;
        end
        ADDR: begin
          for (int i = 1; i < ADDR_BEATS - 1; i++) if (beat_cnt == BW'(i)) slot[i] <= address;
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == BW'(1) && slot[0] != BANK) state <= IDLE;
          else if (beat_cnt == BW'(ADDR_BEATS - 1)) begin
            remain  <= burst ? RW'(BURST_LEN - 1) : '0;
            idx     <= full[MEM_AW-1:0];
            lat_cnt <= LW'(RD_LATENCY);
            state   <= !read ? WR_WAIT : RD_LATENCY == 0 ? RD_DATA : RD_WAIT;
`ifdef SIMPLEBUS_WR_TIMEOUT_EN
            stall   <= '0;
`endif
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LW'(1)) state <= RD_DATA;
        end
        RD_DATA: if (remain != '0) begin
          idx    <= idx + 1'b1;
          remain <= remain - 1'b1;
        end else state <= IDLE;
        WR_WAIT: if (dv_in) begin
          idx <= idx + 1'b1;
          if (remain != '0) remain <= remain - 1'b1;
          else state <= IDLE;
`ifdef SIMPLEBUS_WR_TIMEOUT_EN
          stall <= '0;
        end else if (stall == SW'(TIMEOUT - 1)) begin
          err_q <= 1'b1;
          state <= IDLE;
        end else stall <= stall + 1'b1;
`else
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_simplebus_follower_mem.sv
// tb_simplebus_follower_mem: scoreboard bench with a dictionary memory model and randomized transactions.
module tb_simplebus_follower_mem;
  localparam int LAT = 2, BL = 4, TO = 16;
  logic clock = 0, reset = 1, start = 0, read = 0, burst = 0, dv_in = 0;
  logic [7:0] address = 0, data_in = 0;
  logic [7:0] data_out;
  logic data_oe, dv_out, dv_oe, busy, err;
  int cyc = 0, checks = 0, failures = 0, last_cyc = 0;
  typedef struct { logic [7:0] d; int c; } exp_t;
  exp_t q[$];
  logic [7:0] mdl [logic [15:0]];

  simplebus_follower_mem #(.DATA_W(8), .ADDR_BEATS(3), .BANK_ID(1), .MEM_AW(16),
    .RD_LATENCY(LAT), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .read(read), .burst(burst),
    .address(address), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .dv_in(dv_in), .dv_out(dv_out), .dv_oe(dv_oe), .busy(busy), .err(err));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h01;
  endfunction

  // Any drive of the bus must match the next queued read beat, value and cycle.
  always @(negedge clock) if (!reset && (dv_oe || data_oe || dv_out)) begin
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_drive cyc=%0d data_out=%h dv_oe=%b data_oe=%b", cyc, data_out, dv_oe, data_oe);
    end else begin
      exp_t e;
      e = q.pop_front();
      if (data_out !== e.d || cyc != e.c || dv_oe !== 1'b1 || data_oe !== 1'b1 || dv_out !== 1'b1) begin
        failures++;
        $display("FAIL read_beat got data=%h cyc=%0d oe=%b%b%b want data=%h cyc=%0d oe=111",
                 data_out, cyc, dv_oe, data_oe, dv_out, e.d, e.c);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_addr(input logic [7:0] bank, input logic [15:0] a, input logic rd, input logic bu);
    @(posedge clock); #1;
    start = 1; address = bank;
    @(posedge clock); #1;
    start = 0; address = a[15:8];
    @(posedge clock); #1;
    address = a[7:0]; read = rd; burst = bu;
    @(posedge clock); #1;
    last_cyc = cyc;
    address = 0; read = 0; burst = 0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic bu);
    int n;
    n = bu ? BL : 1;
    do_addr(8'h01, a, 1'b1, bu);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.d = model_rd(a + 16'(k));
      e.c = last_cyc + LAT + k;
      q.push_back(e);
    end
    wait_idle(20);
  endtask

  task automatic do_write(input logic [15:0] a, input logic bu, input logic [7:0] d [4], input logic [3:0] stalls);
    int n;
    n = bu ? BL : 1;
    do_addr(8'h01, a, 1'b0, bu);
    for (int k = 0; k < n; k++) begin
      if (stalls[k]) begin
        dv_in = 0;
        @(posedge clock); #1;
      end
      dv_in = 1; data_in = d[k];
      @(posedge clock); #1;
      mdl[a + 16'(k)] = d[k];
    end
    dv_in = 0;
    wait_idle(20);
  endtask

  initial begin
    logic [7:0] d [4];
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {data_out, data_oe, dv_out, dv_oe, busy, err}, 32'd0);
    reset = 0;
    // Single write then single read with exact latency.
    d = '{8'hDC, 8'h00, 8'h00, 8'h00};
    do_write(16'h0406, 1'b0, d, 4'b0000);
    do_read(16'h0406, 1'b0);
    // Foreign bank: drops after beat 1, never drives.
    @(posedge clock); #1;
    start = 1; address = 8'h02;
    @(posedge clock); #1;
    chk("foreign_busy_beat0", {31'd0, busy}, 32'd1);
    start = 0; address = 8'h04;
    @(posedge clock); #1;
    chk("foreign_busy_beat1", {31'd0, busy}, 32'd0);
    address = 8'h07;
    repeat (6) @(posedge clock);
    #1;
    chk("foreign_idle", {31'd0, busy}, 32'd0);
    // Burst write across wrap with a stall before the third beat, then burst read.
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_write(16'hFFFE, 1'b1, d, 4'b0100);
    do_read(16'hFFFE, 1'b1);
    do_read(16'h0000, 1'b0);
    do_read(16'h0001, 1'b0);
    // Unwritten location holds the bank id.
    do_read(16'h1234, 1'b0);
    // Reset during RD_WAIT clears outputs without a clock edge.
    do_addr(8'h01, 16'h0406, 1'b1, 1'b0);
    #2 reset = 1;
    #1 chk("reset_mid_read", {data_out, data_oe, dv_out, dv_oe, busy, err}, 32'd0);
    @(posedge clock); #3;
    reset = 0;
    do_read(16'h0406, 1'b0);
    // Write with no data beats.
    do_addr(8'h01, 16'h0500, 1'b0, 1'b0);
`ifdef SIMPLEBUS_WR_TIMEOUT_EN
    begin
      int n = 0;
      while (!err && n < 40) begin
        @(posedge clock); #1;
        n++;
      end
      chk("timeout_err_cycle", cyc, last_cyc + TO);
      @(posedge clock); #1;
      chk("timeout_err_pulse", {30'd0, err, busy}, 32'd0);
    end
`else
    repeat (40) @(posedge clock);
    #1;
    chk("wait_forever", {30'd0, busy, err}, 32'd2);
    #2 reset = 1;
    @(posedge clock); #3;
    reset = 0;
`endif
    do_read(16'h0500, 1'b0);
    // Randomized mix near a small window and the wrap point.
    for (int t = 0; t < 30; t++) begin
      logic [15:0] a;
      logic bu;
      a = $urandom_range(0, 1) ? 16'($urandom_range(16'h0100, 16'h010F)) : 16'($urandom_range(16'hFFFA, 16'hFFFF));
      bu = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin
          do_addr(8'($urandom_range(2, 255)), a, 1'($urandom_range(0, 1)), bu);
          wait_idle(20);
        end
        1, 2: begin
          for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
          do_write(a, bu, d, 4'($urandom));
        end
        default: do_read(a, bu);
      endcase
    end
    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/simplebus_follower_mem.md
Name: simplebus_follower_mem

Overview:
Parametrised memory follower for the multiplexed-address simple bus; successor to the fixed 8-bit, 3-beat, single-transfer memory thread.
- Address beats, data width, bank ID, read latency and burst length are all parameters.
- Supports back-to-back burst transfers with address auto-increment.
- Tri-state bus pins are split into in/out/oe triples; the bus wrapper resolves them.
- One instance per bank, N instances share one leader.

Parameters:
DATA_W, 8, width of data and of one address beat
ADDR_BEATS, 3, address beats per transaction (>=2); beat 0 is the most significant (bank select)
BANK_ID, 0, value of beat 0 this instance answers to; also the memory init value
MEM_AW, 16, memory index bits, taken from the low bits of the assembled address; must be <= (ADDR_BEATS-1)*DATA_W
RD_LATENCY, 2, wait cycles between the last address beat and the first read beat (0 allowed)
BURST_LEN, 4, beats per burst transfer (>=2)
TIMEOUT, 16, write-wait limit in cycles (used only with the optional feature)

Ports:
clock  in  1  bus clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  leader marks address beat 0
read  in  1  1 = read, 0 = write; sampled on the last address beat
burst  in  1  1 = BURST_LEN beats, 0 = single beat; sampled on the last address beat
address  in  DATA_W  current address beat
data_in  in  DATA_W  resolved bus data
data_out  out  DATA_W  read data to drive
data_oe  out  1  drive enable for data
dv_in  in  1  resolved dataValid
dv_out  out  1  dataValid value to drive
dv_oe  out  1  drive enable for dataValid
busy  out  1  state != IDLE
err  out  1  one-cycle write-timeout pulse; tied 0 when the feature is compiled out

Behaviour:
- Reset:
  - state=IDLE; data_out=0, data_oe=0, dv_out=0, dv_oe=0, busy=0, err=0.
  - Counters and the address register clear.
  - Memory contents are not reset.
  - Memory is initialised to BANK_ID at time zero.
- States: IDLE, ADDR, RD_WAIT, RD_DATA, WR_WAIT.
- IDLE:
  - start=1 -> capture address into beat slot 0, beat_cnt=1, go to ADDR.
  - start with any other state is ignored.
- ADDR:
  - Each cycle, capture address into slot beat_cnt and increment beat_cnt.
  - First ADDR cycle: if slot 0 != BANK_ID[DATA_W-1:0], go to IDLE. No output is ever driven for a foreign bank.
  - On the cycle where beat_cnt==ADDR_BEATS-1, sample read and burst. Set remain = burst ? BURST_LEN-1 : 0.
  - Then: read=1 -> RD_WAIT with lat_cnt=RD_LATENCY, or straight to RD_DATA if RD_LATENCY==0. read=0 -> WR_WAIT.
- RD_WAIT: decrement lat_cnt; go to RD_DATA in the cycle after it reaches 0. Total: exactly RD_LATENCY cycles in RD_WAIT.
- RD_DATA:
  - Per cycle: data_oe=1, dv_oe=1, dv_out=1, data_out=mem[idx] (combinational read of the current idx).
  - If remain>0: idx <= idx+1 modulo 2^MEM_AW, decrement remain, stay. Burst beats are back-to-back with no gaps.
  - If remain==0: go to IDLE, and all enables drop the next cycle.
- WR_WAIT:
  - When dv_in=1: mem[idx] <= data_in, idx increments with wrap.
  - If remain>0: decrement remain, stay. If remain==0: go to IDLE.
  - Cycles with dv_in=0 are stalls; nothing is written.
- dv_oe is asserted only in RD_DATA; data_oe likewise. The follower never drives during writes.
- The follower does not check bus contention; that is the leader's responsibility.
- Reset asserted mid-transaction: immediate return to IDLE with outputs 0; a partial burst write keeps the beats already written.

Optional Feature:
SIMPLEBUS_WR_TIMEOUT_EN
- With the macro:
  - WR_WAIT runs a stall counter that clears on every dv_in=1 beat.
  - When it reaches TIMEOUT cycles without dv_in: pulse err=1 for one cycle and go to IDLE.
  - The remaining burst beats are abandoned.
- Without the macro:
  - WR_WAIT waits indefinitely.
  - err is constant 0 and no counter logic exists.

Decomposition:
- Package simplebus_pkg:
  - state enum simplebus_fstate_t (IDLE, ADDR, RD_WAIT, RD_DATA, WR_WAIT).
  - Default DATA_W constant.
  - Function clog2-based counter width helper for beat_cnt, lat_cnt and remain.
- Sub-module simplebus_mem_array:
  - Parameters DATA_W and MEM_AW; parameter INIT for the init value.
  - Synchronous write, asynchronous read.
  - Instantiated once.

Test Plan:
(All scenarios use DATA_W=8, ADDR_BEATS=3, BANK_ID=1, RD_LATENCY=2, BURST_LEN=4.)
- Single write then read: write 0x010406 <- 0xDC, then read 0x010406 -> dv_out=1 and data_out=0xDC on the 3rd cycle after the last address beat, dv_oe high for exactly 1 cycle.
- Foreign bank: start with address beats 02,04,07 -> busy drops the cycle after beat 1; data_oe and dv_oe stay 0 throughout.
- Burst with wrap: write at 0x01FFFE data AA,BB,CC,DD with one dv_in stall between BB and CC -> locations FFFE,FFFF,0000,0001 written. Burst read at 0x01FFFE -> AA,BB,CC,DD on 4 consecutive cycles.
- Init value: read 0x011234 with no prior write -> data_out=0x01.
- Reset mid-read: assert reset during RD_WAIT -> all outputs 0 asynchronously. After release, read 0x010406 still returns 0xDC.
- Write timeout: with SIMPLEBUS_WR_TIMEOUT_EN, a write with no dv_in for 16 cycles -> err pulses 1 cycle, busy falls, memory unchanged. Without the macro -> busy stays 1 indefinitely.
